// File: rtl/icache_pkg.sv
// Shared constants for the 2-way instruction cache: FSM encodings and address-field width helpers.
package icache_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_REFILL = 2'd2;
    localparam logic [1:0] S_FLUSH  = 2'd3;

    function automatic int offW(input int dataW);
        return $clog2(dataW / 8);
    endfunction

    function automatic int wselW(input int wordsPerLine);
        return $clog2(wordsPerLine);
    endfunction

    function automatic int idxW(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tagW(input int addrW, input int dataW, input int sets, input int wordsPerLine);
        return addrW - offW(dataW) - wselW(wordsPerLine) - idxW(sets);
    endfunction

endpackage

// File: rtl/icache_2way_if.sv
// Fetch-side and memory-side bus of the 2-way I-cache. The flush input exists only when
// ICACHE_FLUSH_EN is defined.
interface icache_2way_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
`ifdef ICACHE_FLUSH_EN
    logic              flush;
`endif
    logic [ADDR_W-1:0] cpu_req_addr;
    logic              cpu_req_valid;
    logic              cpu_req_ready;
    logic [DATA_W-1:0] cpu_rsp_data;
    logic              cpu_rsp_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_valid;
    logic [DATA_W-1:0] mem_req_data;
    logic              mem_req_ready;

    modport slave (
`ifdef ICACHE_FLUSH_EN
        input  flush,
`endif
        input  cpu_req_addr, cpu_req_valid, mem_req_data, mem_req_ready,
        output cpu_req_ready, cpu_rsp_data, cpu_rsp_valid, mem_req_addr, mem_req_valid
    );

    modport master (
`ifdef ICACHE_FLUSH_EN
        output flush,
`endif
        output cpu_req_addr, cpu_req_valid, mem_req_data, mem_req_ready,
        input  cpu_req_ready, cpu_rsp_data, cpu_rsp_valid, mem_req_addr, mem_req_valid
    );

endinterface

// File: rtl/icache_way.sv
// One way of the I-cache: tag and data arrays (no reset) plus per-set valid flops.
module icache_way import icache_pkg::*; #(
    parameter int    ADDR_W         = 32,
    parameter int    DATA_W         = 32,
    parameter int    SETS           = 16,
    parameter int    WORDS_PER_LINE = 4,
    localparam int   IDX_W          = idxW(SETS),
    localparam int   WSEL_W         = wselW(WORDS_PER_LINE),
    localparam int   TAG_W          = tagW(ADDR_W, DATA_W, SETS, WORDS_PER_LINE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx_i,
    input  logic [WSEL_W-1:0] rd_word_i,
    input  logic [TAG_W-1:0]  rd_tag_i,
    output logic              hit_o,
    output logic              vld_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [WSEL_W-1:0] wr_word_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              set_valid_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic              clr_en_i,
    input  logic [IDX_W-1:0]  clr_idx_i
);

    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tagMem  [SETS];
    logic [DATA_W-1:0] dataMem [SETS*WORDS_PER_LINE];

    assign vld_o  = valid_q[rd_idx_i];
    assign hit_o  = vld_o && (tagMem[rd_idx_i] == rd_tag_i);
    assign data_o = dataMem[{rd_idx_i, rd_word_i}];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (clr_en_i) begin
            valid_q[clr_idx_i] <= 1'b0;
        end else if (set_valid_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // The tag is only written with the last refill word, together with the valid bit.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            dataMem[{wr_idx_i, wr_word_i}] <= wr_data_i;
        end
        if (set_valid_i) begin
            tagMem[wr_idx_i] <= wr_tag_i;
        end
    end

endmodule

// File: rtl/icache_2way.sv
// 2-way set-associative read-only I-cache with per-set LRU and word-by-word burst refill.
// Define ICACHE_FLUSH_EN to add a flush input that invalidates every set.
module icache_2way import icache_pkg::*; #(
    parameter int  ADDR_W         = 32,
    parameter int  DATA_W         = 32,
    parameter int  SETS           = 16,
    parameter int  WORDS_PER_LINE = 4,
    localparam int OFF_W          = offW(DATA_W),
    localparam int WSEL_W         = wselW(WORDS_PER_LINE),
    localparam int IDX_W          = idxW(SETS),
    localparam int TAG_W          = tagW(ADDR_W, DATA_W, SETS, WORDS_PER_LINE),
    localparam int WADDR_W        = ADDR_W - OFF_W
) (
    input  logic       clk,
    input  logic       rst,
    icache_2way_if.slave bus
);

    logic [1:0]         state_q, state_d;
    logic [WADDR_W-1:0] addr_q;
    logic [WSEL_W-1:0]  cnt_q;
    logic               victim_q;
    logic [SETS-1:0]    lru_q;

    logic [TAG_W-1:0]   reqTag;
    logic [IDX_W-1:0]   reqIdx;
    logic [WSEL_W-1:0]  reqWord;
    logic               hit0, hit1, vld0, vld1;
    logic [DATA_W-1:0]  data0, data1;
    logic               idle, lookup, refill, anyHit, missing, missVictim, beat, lastBeat;
    logic [IDX_W-1:0]   clrIdx;
    logic               clr0, clr1;

    assign reqTag  = addr_q[WADDR_W-1 -: TAG_W];
    assign reqIdx  = addr_q[WSEL_W +: IDX_W];
    assign reqWord = addr_q[WSEL_W-1:0];

    assign idle     = (state_q == S_IDLE);
    assign lookup   = (state_q == S_LOOKUP);
    assign refill   = (state_q == S_REFILL);
    assign anyHit   = hit0 || hit1;
    assign missing  = lookup && !anyHit;
    assign beat     = refill && bus.mem_req_ready;
    assign lastBeat = beat && (cnt_q == WSEL_W'(WORDS_PER_LINE - 1));

    // Victim: first invalid way (way0 first), otherwise the way the LRU bit names.
    assign missVictim = !vld0 ? 1'b0 : (!vld1 ? 1'b1 : lru_q[reqIdx]);

`ifdef ICACHE_FLUSH_EN
    logic [IDX_W-1:0] flushIdx_q;
    logic             flushPend_q;
    logic             flushing, flushReq;

    assign flushing = (state_q == S_FLUSH);
    assign flushReq = bus.flush || flushPend_q;
    assign clrIdx   = flushing ? flushIdx_q : reqIdx;
    assign clr0     = (missing && !missVictim) || flushing;
    assign clr1     = (missing && missVictim) || flushing;

    // A flush seen outside IDLE is remembered until the FSM next returns to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flushIdx_q  <= '0;
            flushPend_q <= 1'b0;
        end else begin
            if (flushing) begin
                flushIdx_q <= flushIdx_q + 1'b1;
            end
            if (idle) begin
                flushPend_q <= 1'b0;
            end else if (bus.flush) begin
                flushPend_q <= 1'b1;
            end
        end
    end
`else
    assign clrIdx = reqIdx;
    assign clr0   = missing && !missVictim;
    assign clr1   = missing && missVictim;
`endif

    assign bus.cpu_req_ready = idle;
    assign bus.cpu_rsp_valid = lookup && anyHit;
    assign bus.cpu_rsp_data  = (lookup && anyHit) ? (hit0 ? data0 : data1) : '0;
    assign bus.mem_req_valid = refill;
    assign bus.mem_req_addr  = refill ? (ADDR_W'({addr_q[WADDR_W-1:WSEL_W], cnt_q}) << OFF_W) : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
`ifdef ICACHE_FLUSH_EN
                if (flushReq) state_d = S_FLUSH;
                else
`endif
                if (bus.cpu_req_valid) state_d = S_LOOKUP;
            end
            S_LOOKUP: state_d = anyHit ? S_IDLE : S_REFILL;
            S_REFILL: if (lastBeat) state_d = S_LOOKUP;
`ifdef ICACHE_FLUSH_EN
            S_FLUSH:  if (flushIdx_q == IDX_W'(SETS - 1)) state_d = S_IDLE;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            victim_q <= 1'b0;
            lru_q    <= '0;
        end else begin
            state_q <= state_d;
            if (idle && bus.cpu_req_valid) begin
                addr_q <= bus.cpu_req_addr[ADDR_W-1:OFF_W];
            end
            if (missing) begin
                cnt_q    <= '0;
                victim_q <= missVictim;
            end else if (beat) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (lookup && anyHit) begin
                lru_q[reqIdx] <= hit0;
            end else if (lastBeat) begin
                lru_q[reqIdx] <= ~victim_q;
            end
`ifdef ICACHE_FLUSH_EN
            if (flushing) begin
                lru_q[flushIdx_q] <= 1'b0;
            end
`endif
        end
    end

    icache_way #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(SETS), .WORDS_PER_LINE(WORDS_PER_LINE)
    ) u_way0 (
        .clk(clk), .rst(rst),
        .rd_idx_i(reqIdx), .rd_word_i(reqWord), .rd_tag_i(reqTag),
        .hit_o(hit0), .vld_o(vld0), .data_o(data0),
        .wr_en_i(beat && !victim_q), .wr_idx_i(reqIdx), .wr_word_i(cnt_q),
        .wr_data_i(bus.mem_req_data),
        .set_valid_i(lastBeat && !victim_q), .wr_tag_i(reqTag),
        .clr_en_i(clr0), .clr_idx_i(clrIdx)
    );

    icache_way #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(SETS), .WORDS_PER_LINE(WORDS_PER_LINE)
    ) u_way1 (
        .clk(clk), .rst(rst),
        .rd_idx_i(reqIdx), .rd_word_i(reqWord), .rd_tag_i(reqTag),
        .hit_o(hit1), .vld_o(vld1), .data_o(data1),
        .wr_en_i(beat && victim_q), .wr_idx_i(reqIdx), .wr_word_i(cnt_q),
        .wr_data_i(bus.mem_req_data),
        .set_valid_i(lastBeat && victim_q), .wr_tag_i(reqTag),
        .clr_en_i(clr1), .clr_idx_i(clrIdx)
    );

endmodule

// File: tb/tb_icache_2way.sv
// Directed bench for icache_2way (SETS=16, 4 words/line, 32-bit); memory word at address A is (A>>2)+0x60.
// The flush test is built only when ICACHE_FLUSH_EN is defined.
module tb_icache_2way;

    logic clk;
    logic rst;
    int   total;
    int   passed;

    icache_2way_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    icache_2way #(
        .ADDR_W(32), .DATA_W(32), .SETS(16), .WORDS_PER_LINE(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a >> 2) + 32'h60;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // One fetch, serving refill beats with `stall` idle cycles before each; starts and ends at a negedge in IDLE.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] expData, input int expBeats,
                                 input int stall, input int expCycles);
        int          cycles;
        int          beats;
        int          waited;
        logic [31:0] base;
        base   = a & 32'hFFFF_FFF0;
        cycles = 0;
        beats  = 0;
        waited = 0;
        bus.cpu_req_addr  = a;
        bus.cpu_req_valid = 1'b1;
        checkOutput("req_ready", 32'(bus.cpu_req_ready), 32'd1);
        @(negedge clk);
        bus.cpu_req_valid = 1'b0;
        while (bus.cpu_rsp_valid !== 1'b1 && cycles < 200) begin
            if (waited > 0) checkOutput("mem_valid_stall", 32'(bus.mem_req_valid), 32'd1);
            if (bus.mem_req_valid === 1'b1) begin
                checkOutput("mem_addr", bus.mem_req_addr, base + 32'(beats) * 32'd4);
                if (waited < stall) begin
                    waited++;
                end else begin
                    bus.mem_req_ready = 1'b1;
                    bus.mem_req_data  = memWord(bus.mem_req_addr);
                end
            end
            @(negedge clk);
            cycles++;
            if (bus.mem_req_ready) begin
                beats++;
                waited = 0;
                bus.mem_req_ready = 1'b0;
            end
        end
        checkOutput("rsp_latency", 32'(cycles), 32'(expCycles));
        checkOutput("rsp_data", bus.cpu_rsp_data, expData);
        checkOutput("mem_beats", 32'(beats), 32'(expBeats));
        @(negedge clk);
        checkOutput("rsp_pulse", 32'(bus.cpu_rsp_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired observed=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        total = 0;
        passed = 0;
        rst = 1'b1;
        bus.cpu_req_addr  = '0;
        bus.cpu_req_valid = 1'b0;
        bus.mem_req_data  = '0;
        bus.mem_req_ready = 1'b0;
`ifdef ICACHE_FLUSH_EN
        bus.flush = 1'b0;
`endif
        #1 rst = 1'b0;
        #1;
        checkOutput("rst_req_ready", 32'(bus.cpu_req_ready), 32'd1);
        checkOutput("rst_rsp_valid", 32'(bus.cpu_rsp_valid), 32'd0);
        checkOutput("rst_rsp_data", bus.cpu_rsp_data, 32'd0);
        checkOutput("rst_mem_valid", 32'(bus.mem_req_valid), 32'd0);
        checkOutput("rst_mem_addr", bus.mem_req_addr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] cold miss 0x104, then hit 0x108");
        applyStimulus(32'h104, 32'hA1, 4, 0, 5);
        applyStimulus(32'h108, 32'hA2, 0, 0, 0);

        $display("[TB] conflict and LRU in set 0");
        applyStimulus(32'h000, 32'h60, 4, 0, 5);
        applyStimulus(32'h000, 32'h60, 0, 0, 0);
        applyStimulus(32'h200, 32'hE0, 4, 0, 5);
        applyStimulus(32'h000, 32'h60, 0, 0, 0);
        applyStimulus(32'h100, 32'hA0, 4, 0, 5);
        applyStimulus(32'h004, 32'h61, 0, 0, 0);

        $display("[TB] memory stall, 5 idle cycles per beat");
        applyStimulus(32'h454, 32'h175, 4, 5, 25);

        $display("[TB] back-to-back hits on line 0x000");
        bus.cpu_req_addr  = 32'h000;
        bus.cpu_req_valid = 1'b1;
        checkOutput("b2b_ready_0", 32'(bus.cpu_req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("b2b_rsp_valid", 32'(bus.cpu_rsp_valid), 32'd1);
            checkOutput("b2b_rsp_data", bus.cpu_rsp_data, 32'h60 + 32'(i));
            checkOutput("b2b_ready_low", 32'(bus.cpu_req_ready), 32'd0);
            checkOutput("b2b_mem_valid", 32'(bus.mem_req_valid), 32'd0);
            if (i < 3) begin
                bus.cpu_req_addr = 32'(i + 1) * 32'd4;
            end else begin
                bus.cpu_req_valid = 1'b0;
            end
            @(negedge clk);
            checkOutput("b2b_ready_high", 32'(bus.cpu_req_ready), 32'd1);
            checkOutput("b2b_rsp_idle", 32'(bus.cpu_rsp_valid), 32'd0);
        end

        $display("[TB] reset during refill of 0x300");
        bus.cpu_req_addr  = 32'h300;
        bus.cpu_req_valid = 1'b1;
        @(negedge clk);
        bus.cpu_req_valid = 1'b0;
        @(negedge clk);
        checkOutput("mr_addr0", bus.mem_req_addr, 32'h300);
        bus.mem_req_ready = 1'b1;
        bus.mem_req_data  = memWord(32'h300);
        @(negedge clk);
        bus.mem_req_data  = memWord(32'h304);
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        checkOutput("mr_valid_beat2", 32'(bus.mem_req_valid), 32'd1);
        checkOutput("mr_addr_beat2", bus.mem_req_addr, 32'h308);
        #2 rst = 1'b0;
        #1;
        checkOutput("mr_rst_mem_valid", 32'(bus.mem_req_valid), 32'd0);
        checkOutput("mr_rst_mem_addr", bus.mem_req_addr, 32'd0);
        checkOutput("mr_rst_req_ready", 32'(bus.cpu_req_ready), 32'd1);
        checkOutput("mr_rst_rsp_valid", 32'(bus.cpu_rsp_valid), 32'd0);
        checkOutput("mr_rst_rsp_data", bus.cpu_rsp_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(32'h300, 32'h120, 4, 0, 5);
        applyStimulus(32'h108, 32'hA2, 4, 0, 5);

`ifdef ICACHE_FLUSH_EN
        begin
            int busy;
            $display("[TB] flush after fills");
            applyStimulus(32'h000, 32'h60, 4, 0, 5);
            applyStimulus(32'h000, 32'h60, 0, 0, 0);
            bus.flush = 1'b1;
            checkOutput("flush_ready_before", 32'(bus.cpu_req_ready), 32'd1);
            @(negedge clk);
            bus.flush = 1'b0;
            busy = 0;
            while (bus.cpu_req_ready !== 1'b1 && busy < 100) begin
                busy++;
                @(negedge clk);
            end
            checkOutput("flush_busy_cycles", 32'(busy), 32'd16);
            applyStimulus(32'h000, 32'h60, 4, 0, 5);
        end
`endif

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/icache_2way.md
Name: icache_2way

Overview:
- Parametrised read-only instruction cache: 2-way set-associative, multi-word lines, per-set LRU, word-by-word burst refill.
- Sits between the fetch stage and the instruction memory port.
- Successor to the single-word direct-mapped I-cache. It generalises data/address width, set count and line length, and adds associativity and replacement.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, instruction word width (power of two, at least 8).
- SETS, 16, number of sets (power of two, at least 2).
- WORDS_PER_LINE, 4, words per line (power of two, at least 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req_addr  in  ADDR_W  fetch byte address (low log2(DATA_W/8) bits ignored).
- cpu_req_valid  in  1  fetch request.
- cpu_req_ready  out  1  request accepted when valid&&ready.
- cpu_rsp_data  out  DATA_W  fetched word.
- cpu_rsp_valid  out  1  one-cycle pulse, data valid.
- mem_req_addr  out  ADDR_W  word-aligned refill address.
- mem_req_valid  out  1  refill word request.
- mem_req_data  in  DATA_W  refill data.
- mem_req_ready  in  1  memory returns mem_req_data this cycle; completes the current word.

Behaviour:
- Address split, low to high:
  - byte offset: log2(DATA_W/8) bits
  - word select: log2(WORDS_PER_LINE) bits
  - index: log2(SETS) bits
  - tag: the remaining bits
- Storage per way: valid bit per set (flops, reset), tag array, data array (no reset). One LRU bit per set (flops, reset to 0); the bit names the way to replace.
- Reset values (async, rst=0):
  - State=IDLE.
  - cpu_req_ready=1, cpu_rsp_valid=0, cpu_rsp_data=0.
  - mem_req_valid=0, mem_req_addr=0.
  - All valid and LRU bits = 0.
- States and transitions:
  - IDLE: cpu_req_ready=1. On valid&&ready, register the address and go to LOOKUP.
  - LOOKUP: cpu_req_ready=0; compare both ways.
    - Hit: cpu_rsp_valid=1, cpu_rsp_data=selected word, LRU[set]=~hit_way, go to IDLE.
    - Miss: choose victim (first invalid way, way0 priority; else LRU[set]), clear word counter, go to REFILL.
  - REFILL: mem_req_valid=1, mem_req_addr={tag,index,cnt,0}.
    - Each cycle with mem_req_ready=1: write mem_req_data to victim word cnt, cnt++.
    - When the last word is accepted: write tag, set valid, LRU[set]=~victim, drop mem_req_valid the next cycle, go to LOOKUP (guaranteed hit).
- Latency:
  - Hit: response in the cycle after acceptance.
  - Miss: WORDS_PER_LINE memory beats + 2 cycles.
- Handshake rules:
  - The cache holds mem_req_valid and mem_req_addr stable until mem_req_ready.
  - The response is a single pulse; the CPU must sample it.
  - A new request is never accepted outside IDLE.
- Memory port: mem_req_ready while mem_req_valid=0 is ignored.
- Valid bit during refill: not set until the final word, so a partial line is never hit.
- Reset mid-refill: everything is abandoned, the line stays invalid, no memory request persists.
- Both ways hitting (unreachable by construction): way0 wins.

Optional Feature:
- ICACHE_FLUSH_EN defined:
  - Adds input flush (1 bit), sampled in IDLE with priority over cpu_req_valid.
  - FLUSH state clears valid and LRU of one set per cycle, index 0..SETS-1, so it takes SETS cycles.
  - cpu_req_ready=0 throughout; returns to IDLE.
  - flush outside IDLE is latched and honoured on the next IDLE.
- Undefined: no flush port, no FLUSH state; lines are invalidated only by reset.

Decomposition:
- Package icache_pkg:
  - state enum (IDLE, LOOKUP, REFILL, FLUSH)
  - localparam helpers for OFF_W, WSEL_W, IDX_W, TAG_W computed with $clog2
- Sub-module icache_way, instantiated twice:
  - holds the tag array, data array and valid flops for one way
  - ports: read index/word, tag-compare hit output, refill write port, set-valid, clear-valid by index

Test Plan (SETS=16, WORDS_PER_LINE=4, DATA_W=32):
- Cold miss at 0x104:
  - Stimulus: fetch 0x104; memory returns 0xA0, 0xA1, 0xA2, 0xA3.
  - Required: mem requests 0x100, 0x104, 0x108, 0x10C in order; cpu_rsp_data=0xA1.
  - Then fetch 0x108: rsp 0xA2 one cycle after acceptance, mem_req_valid stays 0.
- Conflict and LRU:
  - Stimulus: fill 0x000 and 0x100 (both set 0), fetch 0x000 (hit, LRU→way1), then fetch 0x200.
  - Required: miss refills way1; fetch 0x000 still hits; fetch 0x100 misses.
- Memory stall:
  - Stimulus: mem_req_ready low for 5 cycles before each beat.
  - Required: mem_req_addr and mem_req_valid stable while stalled; 4 beats total; data correct.
- Reset mid-refill:
  - Stimulus: assert rst after beat 2 of 0x300.
  - Required: outputs take reset values immediately, asynchronously; re-fetch 0x300 misses and refills 4 beats.
- Back-to-back fetches:
  - Stimulus: cpu_req_valid held high across 0x000, 0x004, 0x008, 0x00C after fill.
  - Required: ready pattern 1,0,1,0…; four responses with no memory traffic.
- Flush (ICACHE_FLUSH_EN):
  - Stimulus: pulse flush in IDLE after fills.
  - Required: cpu_req_ready=0 for 16 cycles; previously cached 0x000 then misses.
